simple_mem_arbiter: RTL and testbench
=====================================

# simple_mem_arbiter

Two-master arbiter and sequencer for the single simple-bus memory port. It sits between the instruction fetch unit (IFU) and load/store unit (LSU) on one side and the simulation memory on the other. It grants one master at a time round-robin, drives the memory request until accepted, and waits a fixed response latency. It then returns the read data, or a write acknowledge, to the granted master as a one-cycle pulse.

## Interface
- RESP_LATENCY, 2: cycles from memory acceptance (cycle A) to the cycle in which mem_rdata is valid (cycle A+RESP_LATENCY); legal range 1..15
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- ifu_req_valid / lsu_req_valid  in  1  master request
- ifu_req_addr / lsu_req_addr  in  32  byte address
- ifu_req_writeEn / lsu_req_writeEn  in  1  1 = write
- ifu_req_size / lsu_req_size  in  3  access size code, passed through unchanged
- ifu_req_wdata / lsu_req_wdata  in  32  write data
- ifu_req_ready / lsu_req_ready  out  1  request accepted (grant) this cycle
- ifu_resp_valid / lsu_resp_valid  out  1  one-cycle response pulse
- ifu_resp_rdata / lsu_resp_rdata  out  32  captured read data; valid only with resp_valid
- mem_valid  out  1  memory request valid
- mem_addr / mem_writeEn / mem_size / mem_wdata  out  32/1/3/32  latched request fields
- mem_ready  in  1  memory accepts when mem_valid && mem_ready
- mem_rdata  in  32  memory read data

## Operation
- One transaction outstanding at most. FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: if any req_valid, grant one master.
  - Assert that master's req_ready combinationally in the same cycle.
  - Latch addr, writeEn, size, wdata into the mem_* registers and record the owner.
  - Go to REQ.
- Arbitration:
  - Only one valid: grant it.
  - Both valid: grant the master not granted last; update last_grant on every grant.
  - last_grant resets to LSU, so IFU wins the first tie.
- REQ: mem_valid=1 with latched fields held stable.
  - mem_ready=1: go to WAIT, load cnt=RESP_LATENCY-1.
  - mem_ready=0: stay in REQ.
- WAIT: if cnt==0, capture mem_rdata into resp_rdata and go to RESP; else decrement cnt.
- RESP: owner's resp_valid=1 for exactly one cycle; next state IDLE.
  - Writes also get the pulse, as an acknowledge.
  - Non-owner resp_valid stays 0.
- Both req_ready are 0 in REQ, WAIT and RESP. A new grant is possible only in IDLE.
- Masters must consume the response in the pulse cycle; there is no response backpressure.
- Masters hold req fields stable while req_valid=1 and req_ready=0. Dropping req_valid before a grant is permitted.

## Timing
- Reset values (outputs, cycle after the reset edge):
  - state=IDLE, mem_valid=0, both req_ready=0, both resp_valid=0.
  - resp_rdata=0; mem_addr, mem_writeEn, mem_size, mem_wdata=0.
  - cnt=0, last_grant=LSU.
- Grant in cycle G; mem_valid high from G+1; acceptance cycle A≥G+1.
- resp_valid in cycle A+RESP_LATENCY+1; IDLE at A+RESP_LATENCY+2.
- Zero-wait memory with RESP_LATENCY=2:
  - G, REQ, WAIT, WAIT, RESP = 5 cycles per transaction.
  - Next grant at G+5.
- mem_ready stalls lengthen REQ only; fields and owner stay unchanged.
- Reset in any state: transaction abandoned, no resp_valid pulse, mem_valid=0 the cycle after the reset edge, last_grant returns to LSU.
- req_valid during reset is ignored; grant possible in the first cycle with reset=0.
- resp_rdata holds its last captured value outside RESP.

## Test plan
- Reset with both req_valid=1 for 3 cycles:
  - All ready/valid outputs stay 0.
  - First cycle after release: ifu_req_ready=1, lsu_req_ready=0.
- IFU read 0x80000000, mem_ready=1, model drives mem_rdata=0x00000413 in cycle A+2:
  - mem_valid only at G+1.
  - ifu_resp_valid only at G+4 with rdata 0x00000413.
  - lsu_resp_valid never asserts.
- Both masters valid continuously:
  - Grants alternate IFU, LSU, IFU, LSU at G, G+5, G+10, G+15.
  - Each resp pulse goes to the correct owner.
- LSU write addr 0x80001000, size 2, wdata 0xDEADBEEF, mem_ready low for 3 cycles:
  - mem_valid high 4 cycles with fields stable.
  - lsu_resp_valid one cycle, 3 cycles after acceptance.
- Reset asserted during WAIT:
  - No resp_valid pulse; mem_valid=0 next cycle.
  - A fresh LSU request afterwards completes normally.
- RESP_LATENCY=1 build, single IFU read, zero-wait memory: ifu_resp_valid at G+3, next grant at G+4.

Source files
------------

// File: rtl/simple_mem_arbiter.sv
// Two-master (IFU/LSU) round-robin arbiter and sequencer for a single simple-bus memory port.
// Holds at most one transaction and returns a one-cycle response pulse after a fixed latency.
module simple_mem_arbiter #(
  parameter int RESP_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_req_valid,
  input  logic [31:0] ifu_req_addr,
  input  logic        ifu_req_writeEn,
  input  logic [2:0]  ifu_req_size,
  input  logic [31:0] ifu_req_wdata,
  output logic        ifu_req_ready,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_resp_rdata,
  input  logic        lsu_req_valid,
  input  logic [31:0] lsu_req_addr,
  input  logic        lsu_req_writeEn,
  input  logic [2:0]  lsu_req_size,
  input  logic [31:0] lsu_req_wdata,
  output logic        lsu_req_ready,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_resp_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic        mem_writeEn,
  output logic [2:0]  mem_size,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic       SEL_IFU  = 1'b0;
  localparam logic       SEL_LSU  = 1'b1;
  localparam logic [3:0] CNT_INIT = 4'(RESP_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        owner;
  logic        last_grant;
  logic [3:0]  cnt;
  logic [31:0] resp_rdata;
  logic        grant_ifu;
  logic        grant_lsu;

  // LSU wins when it is the only requester, or on a tie when IFU was served last.
  function automatic logic pick_lsu(input logic ifu_v, input logic lsu_v, input logic last);
    return lsu_v && (!ifu_v || (last == SEL_IFU));
  endfunction

  always_comb begin
    state_nxt = state;
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    case (state)
      IDLE: begin
        if (!reset) begin
          if (pick_lsu(ifu_req_valid, lsu_req_valid, last_grant)) begin
            grant_lsu = 1'b1;
            state_nxt = REQ;
          end else if (ifu_req_valid) begin
            grant_ifu = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ:  if (mem_ready) state_nxt = WAIT;
      WAIT: if (cnt == 4'd0) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= SEL_IFU;
      last_grant  <= SEL_LSU;
      cnt         <= 4'd0;
      mem_addr    <= 32'd0;
      mem_writeEn <= 1'b0;
      mem_size    <= 3'd0;
      mem_wdata   <= 32'd0;
      resp_rdata  <= 32'd0;
    end else begin
      state <= state_nxt;
      if (grant_ifu || grant_lsu) begin
        owner       <= grant_lsu;
        last_grant  <= grant_lsu;
        mem_addr    <= grant_lsu ? lsu_req_addr    : ifu_req_addr;
        mem_writeEn <= grant_lsu ? lsu_req_writeEn : ifu_req_writeEn;
        mem_size    <= grant_lsu ? lsu_req_size    : ifu_req_size;
        mem_wdata   <= grant_lsu ? lsu_req_wdata   : ifu_req_wdata;
      end
      if (state == REQ && mem_ready) begin
        cnt <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Writes capture too; the value is simply ignored by the master.
      if (state == WAIT && cnt == 4'd0) begin
        resp_rdata <= mem_rdata;
      end
    end
  end

  assign ifu_req_ready  = grant_ifu;
  assign lsu_req_ready  = grant_lsu;
  assign mem_valid      = (state == REQ);
  assign ifu_resp_valid = (state == RESP) && (owner == SEL_IFU);
  assign lsu_resp_valid = (state == RESP) && (owner == SEL_LSU);
  assign ifu_resp_rdata = resp_rdata;
  assign lsu_resp_rdata = resp_rdata;

endmodule

// File: tb/tb_simple_mem_arbiter.sv
// Bench for simple_mem_arbiter: directed scenarios plus random traffic against a
// transaction-timing reference model; a second instance covers RESP_LATENCY=1.
module tb_simple_mem_arbiter;

  localparam int L = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        ifu_req_valid = 1'b0, lsu_req_valid = 1'b0;
  logic [31:0] ifu_req_addr = '0, lsu_req_addr = '0;
  logic        ifu_req_writeEn = 1'b0, lsu_req_writeEn = 1'b0;
  logic [2:0]  ifu_req_size = '0, lsu_req_size = '0;
  logic [31:0] ifu_req_wdata = '0, lsu_req_wdata = '0;
  logic        ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid;
  logic [31:0] ifu_resp_rdata, lsu_resp_rdata;
  logic        mem_valid, mem_writeEn;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_size;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        b_reset = 1'b1;
  logic        b_ifu_req_valid = 1'b0;
  logic        b_ifu_req_ready, b_lsu_req_ready, b_ifu_resp_valid, b_lsu_resp_valid;
  logic [31:0] b_ifu_resp_rdata, b_lsu_resp_rdata;
  logic        b_mem_valid, b_mem_writeEn;
  logic [31:0] b_mem_addr, b_mem_wdata;
  logic [2:0]  b_mem_size;
  logic        b_mem_ready = 1'b1;
  logic [31:0] b_mem_rdata = '0;

  simple_mem_arbiter #(.RESP_LATENCY(L)) dut (
    .clock(clk), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr),
    .ifu_req_writeEn(ifu_req_writeEn), .ifu_req_size(ifu_req_size),
    .ifu_req_wdata(ifu_req_wdata), .ifu_req_ready(ifu_req_ready),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_rdata(ifu_resp_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_addr(lsu_req_addr),
    .lsu_req_writeEn(lsu_req_writeEn), .lsu_req_size(lsu_req_size),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_ready(lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_writeEn(mem_writeEn),
    .mem_size(mem_size), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  simple_mem_arbiter #(.RESP_LATENCY(1)) dut1 (
    .clock(clk), .reset(b_reset),
    .ifu_req_valid(b_ifu_req_valid), .ifu_req_addr(32'h80000000),
    .ifu_req_writeEn(1'b0), .ifu_req_size(3'd2),
    .ifu_req_wdata(32'd0), .ifu_req_ready(b_ifu_req_ready),
    .ifu_resp_valid(b_ifu_resp_valid), .ifu_resp_rdata(b_ifu_resp_rdata),
    .lsu_req_valid(1'b0), .lsu_req_addr(32'd0),
    .lsu_req_writeEn(1'b0), .lsu_req_size(3'd0),
    .lsu_req_wdata(32'd0), .lsu_req_ready(b_lsu_req_ready),
    .lsu_resp_valid(b_lsu_resp_valid), .lsu_resp_rdata(b_lsu_resp_rdata),
    .mem_valid(b_mem_valid), .mem_addr(b_mem_addr), .mem_writeEn(b_mem_writeEn),
    .mem_size(b_mem_size), .mem_wdata(b_mem_wdata),
    .mem_ready(b_mem_ready), .mem_rdata(b_mem_rdata)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one transaction described by its grant/acceptance times.
  int          cyc = 0;
  bit          m_busy = 0, m_owner = 0, m_acc = 0, m_last = 1;
  int          m_acc_cyc = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic        m_we = 1'b0;
  logic [2:0]  m_size = '0;

  int          g_cyc[$];
  bit          g_own[$];
  int          r_cyc[$];
  bit          r_own[$];
  logic [31:0] r_dat[$];
  int          mv_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    g_cyc.delete(); g_own.delete(); r_cyc.delete(); r_own.delete(); r_dat.delete();
    mv_cnt = 0;
  endtask

  // Called at posedge+1 with inputs already applied; checks, updates model, advances a cycle.
  task automatic tick();
    bit ei, el, ev, eri, erl;
    #1;
    ei = 0; el = 0;
    if (!reset && !m_busy) begin
      if (lsu_req_valid && (!ifu_req_valid || !m_last)) el = 1;
      else if (ifu_req_valid) ei = 1;
    end
    ev  = m_busy && !m_acc;
    eri = m_busy && m_acc && (cyc == m_acc_cyc + L + 1) && !m_owner;
    erl = m_busy && m_acc && (cyc == m_acc_cyc + L + 1) && m_owner;
    chk1("ifu_req_ready", ifu_req_ready, ei);
    chk1("lsu_req_ready", lsu_req_ready, el);
    chk1("mem_valid", mem_valid, ev);
    chk("mem_addr", mem_addr, m_addr);
    chk1("mem_writeEn", mem_writeEn, m_we);
    chk("mem_size", 32'(mem_size), 32'(m_size));
    chk("mem_wdata", mem_wdata, m_wdata);
    chk1("ifu_resp_valid", ifu_resp_valid, eri);
    chk1("lsu_resp_valid", lsu_resp_valid, erl);
    chk("ifu_resp_rdata", ifu_resp_rdata, m_rdata);
    chk("lsu_resp_rdata", lsu_resp_rdata, m_rdata);
    if (ifu_req_ready === 1'b1) begin g_cyc.push_back(cyc); g_own.push_back(0); end
    if (lsu_req_ready === 1'b1) begin g_cyc.push_back(cyc); g_own.push_back(1); end
    if (ifu_resp_valid === 1'b1) begin r_cyc.push_back(cyc); r_own.push_back(0); r_dat.push_back(ifu_resp_rdata); end
    if (lsu_resp_valid === 1'b1) begin r_cyc.push_back(cyc); r_own.push_back(1); r_dat.push_back(lsu_resp_rdata); end
    if (mem_valid === 1'b1) mv_cnt++;
    if (reset) begin
      m_busy = 0; m_acc = 0; m_last = 1; m_owner = 0;
      m_addr = '0; m_we = 1'b0; m_size = '0; m_wdata = '0; m_rdata = '0;
    end else if (!m_busy) begin
      if (ei || el) begin
        m_busy = 1; m_acc = 0; m_owner = el; m_last = el;
        m_addr  = el ? lsu_req_addr    : ifu_req_addr;
        m_we    = el ? lsu_req_writeEn : ifu_req_writeEn;
        m_size  = el ? lsu_req_size    : ifu_req_size;
        m_wdata = el ? lsu_req_wdata   : ifu_req_wdata;
      end
    end else if (!m_acc) begin
      if (mem_ready) begin m_acc = 1; m_acc_cyc = cyc; end
    end else begin
      if (cyc == m_acc_cyc + L) m_rdata = mem_rdata;
      if (cyc == m_acc_cyc + L + 1) m_busy = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (m_busy && n < budget) begin
      tick();
      n++;
    end
    if (m_busy) begin
      vectors++;
      miscompares++;
      $error("FAIL drain_timeout observed=busy expected=idle within %0d cycles", budget);
    end
  endtask

  initial begin
    int g;
    #1_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    // Reset held with both masters requesting; IFU wins the first tie.
    ifu_req_valid = 1; ifu_req_addr = 32'h80000100; ifu_req_size = 3'd2; ifu_req_wdata = 32'h11111111;
    lsu_req_valid = 1; lsu_req_addr = 32'h80000200; lsu_req_size = 3'd1; lsu_req_wdata = 32'h22222222;
    mem_ready = 1;
    @(posedge clk); #1;
    repeat (3) tick();
    clear_logs();
    reset = 0;
    tick();
    chk("first_grant_count", g_cyc.size(), 1);
    chk1("first_grant_owner_ifu", g_own[0], 1'b0);
    ifu_req_valid = 0; lsu_req_valid = 0;
    drain(20);

    // Single IFU read, zero-wait memory, data valid at A+2.
    clear_logs();
    ifu_req_valid = 1; ifu_req_addr = 32'h80000000; ifu_req_writeEn = 0; ifu_req_size = 3'd2;
    mem_ready = 1; mem_rdata = 32'hBAD0BAD0;
    tick(); g = cyc - 1;
    ifu_req_valid = 0;
    tick(); tick();
    mem_rdata = 32'h00000413;
    tick();
    mem_rdata = 32'hBAD0BAD0;
    tick(); tick();
    chk("ifu_read_mem_valid_cycles", mv_cnt, 1);
    chk("ifu_read_resp_count", r_cyc.size(), 1);
    chk1("ifu_read_resp_owner", r_own[0], 1'b0);
    chk("ifu_read_resp_cycle", r_cyc[0] - g, 4);
    chk("ifu_read_resp_data", r_dat[0], 32'h00000413);

    // Both masters continuously valid: strict alternation every 5 cycles.
    reset = 1; tick(); reset = 0;
    clear_logs();
    ifu_req_valid = 1; ifu_req_addr = 32'h80000400; ifu_req_writeEn = 0;
    lsu_req_valid = 1; lsu_req_addr = 32'h80000800; lsu_req_writeEn = 1; lsu_req_wdata = 32'hCAFEF00D;
    mem_ready = 1;
    repeat (20) begin
      mem_rdata = $urandom;
      tick();
    end
    ifu_req_valid = 0; lsu_req_valid = 0;
    chk("arb_grant_count", g_cyc.size(), 4);
    chk("arb_resp_count", r_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < g_cyc.size() && i < r_cyc.size()) begin
        chk1("arb_grant_owner", g_own[i], 1'(i % 2));
        chk("arb_grant_spacing", g_cyc[i] - g_cyc[0], 5 * i);
        chk1("arb_resp_owner", r_own[i], g_own[i]);
      end
    end
    drain(20);

    // LSU write stalled by mem_ready for 3 cycles.
    clear_logs();
    lsu_req_valid = 1; lsu_req_addr = 32'h80001000; lsu_req_writeEn = 1;
    lsu_req_size = 3'd2; lsu_req_wdata = 32'hDEADBEEF;
    mem_ready = 0;
    tick(); g = cyc - 1;
    lsu_req_valid = 0;
    repeat (3) tick();
    mem_ready = 1;
    repeat (5) tick();
    chk("stall_mem_valid_cycles", mv_cnt, 4);
    chk("stall_resp_count", r_cyc.size(), 1);
    chk1("stall_resp_owner", r_own[0], 1'b1);
    chk("stall_resp_cycle", r_cyc[0] - g, 7);

    // Reset during WAIT abandons the transaction; a fresh LSU read then completes.
    clear_logs();
    ifu_req_valid = 1; ifu_req_addr = 32'h80002000; ifu_req_writeEn = 0;
    mem_ready = 1;
    tick();
    ifu_req_valid = 0;
    tick(); tick();
    reset = 1; tick(); reset = 0;
    repeat (4) tick();
    chk("wait_reset_resp_count", r_cyc.size(), 0);
    lsu_req_valid = 1; lsu_req_addr = 32'h80003000; lsu_req_writeEn = 0;
    tick();
    lsu_req_valid = 0;
    drain(20);
    chk("post_reset_resp_count", r_cyc.size(), 1);
    chk1("post_reset_resp_owner", r_own[0], 1'b1);

    // Random traffic, stalls and occasional reset.
    for (int i = 0; i < 1500; i++) begin
      if (!ifu_req_valid || ifu_req_ready === 1'b1) begin
        ifu_req_valid = ($urandom_range(0, 2) == 0);
        ifu_req_addr = $urandom; ifu_req_writeEn = 1'($urandom_range(0, 1));
        ifu_req_size = 3'($urandom_range(0, 7)); ifu_req_wdata = $urandom;
      end else if ($urandom_range(0, 7) == 0) begin
        ifu_req_valid = 0;
      end
      if (!lsu_req_valid || lsu_req_ready === 1'b1) begin
        lsu_req_valid = ($urandom_range(0, 2) == 0);
        lsu_req_addr = $urandom; lsu_req_writeEn = 1'($urandom_range(0, 1));
        lsu_req_size = 3'($urandom_range(0, 7)); lsu_req_wdata = $urandom;
      end else if ($urandom_range(0, 7) == 0) begin
        lsu_req_valid = 0;
      end
      reset = ($urandom_range(0, 199) == 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      mem_rdata = $urandom;
      tick();
    end
    reset = 0; ifu_req_valid = 0; lsu_req_valid = 0; mem_ready = 1;
    drain(40);

    // RESP_LATENCY=1 instance: response at G+3, next grant at G+4.
    reset = 1;
    b_reset = 0; b_ifu_req_valid = 1; b_mem_ready = 1; b_mem_rdata = 32'h12345678;
    #1;
    chk1("l1_grant", b_ifu_req_ready, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #2;
      chk1("l1_req_ready", b_ifu_req_ready, k == 4);
      chk1("l1_resp_valid", b_ifu_resp_valid, k == 3);
      if (k == 3) chk("l1_resp_rdata", b_ifu_resp_rdata, 32'h12345678);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
